// File: rtl/div_repsub_if.sv
// Operand/result bus between the system controller and the repeated-subtraction divider.
interface div_repsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;
    logic             busy;
    logic             done;

    modport master (
        output start, data_in,
        input  quotient, remainder, dbz, busy, done
    );

    modport slave (
        input  start, data_in,
        output quotient, remainder, dbz, busy, done
    );
endinterface

// File: rtl/div_repsub.sv
// Sequential unsigned divider by repeated subtraction; operands arrive on one bus
// over two cycles (dividend, then divisor), results held until the next completion.
module div_repsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    div_repsub_if.slave  bus
);
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        CALC = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] rem_w, rem_d;
    logic [WIDTH-1:0] quo_w, quo_d;
    logic [WIDTH-1:0] div_r, div_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // State, working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem_w       <= '0;
            quo_w       <= '0;
            div_r       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_d;
            rem_w       <= rem_d;
            quo_w       <= quo_d;
            div_r       <= div_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state;
        rem_d       = rem_w;
        quo_d       = quo_w;
        div_d       = div_r;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state)
            IDLE: begin
                if (bus.start) state_d = LDA;
            end
            LDA: begin
                rem_d   = bus.data_in;
                state_d = LDB;
            end
            LDB: begin
                div_d   = bus.data_in;
                quo_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                if (div_r == '0) begin
                    quo_d       = '1;
                    quotient_d  = '1;
                    remainder_d = rem_w;
                    dbz_d       = 1'b1;
                    state_d     = DONE;
                end else if (rem_w >= div_r) begin
                    // Compare guards the subtract, so it never underflows.
                    rem_d = rem_w - div_r;
                    quo_d = quo_w + WIDTH'(1);
                end else begin
                    quotient_d  = quo_w;
                    remainder_d = rem_w;
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered from next state so busy/done line up exactly with the state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.dbz       = dbz_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_div_repsub.sv
// Directed-vector bench for div_repsub: results, dbz, done latency, busy length, reset abort.
module tb_div_repsub;
    localparam int unsigned WIDTH = 16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    div_repsub_if #(.WIDTH(WIDTH)) bus ();

    div_repsub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launches one operation from IDLE (called #1 after a posedge) and checks it.
    // k is the index of the edge just passed, with k=0 the edge sampling start.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er, input logic edbz,
                          input int elat, input bit pulse);
        int k;
        int done_edge;
        int busy_cnt;
        int done_cnt;
        bit finished;
        k = -1;
        done_edge = -1;
        busy_cnt = 0;
        done_cnt = 0;
        finished = 1'b0;
        bus.start   = 1'b1;
        bus.data_in = a;
        while (!finished) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = k;
            end
            if (k == 0) bus.start = 1'b0;
            if (k == 1) bus.data_in = b;
            if (k == 2) bus.data_in = 16'hBEEF;
            if (pulse && k >= 3 && done_edge < 0) bus.start = k[0];
            if (done_edge >= 0) bus.start = 1'b0;
            if (done_edge >= 0 && !bus.busy) finished = 1'b1;
            if (k > elat + 40) begin
                check({tag, " timeout"}, 32'(k), 32'(elat));
                finished = 1'b1;
            end
        end
        check({tag, " quotient"},  32'(bus.quotient),  32'(eq));
        check({tag, " remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, " dbz"},       32'(bus.dbz),       32'(edbz));
        check({tag, " done_edge"}, 32'(done_edge),     32'(elat));
        check({tag, " done_cnt"},  32'(done_cnt),      32'd1);
        check({tag, " busy_cnt"},  32'(busy_cnt),      32'(elat + 1));
    endtask

    initial begin
        int done_seen;
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst quotient",  32'(bus.quotient),  32'd0);
        check("rst remainder", 32'(bus.remainder), 32'd0);
        check("rst dbz",       32'(bus.dbz),       32'd0);
        check("rst busy",      32'(bus.busy),      32'd0);
        check("rst done",      32'(bus.done),      32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("100/7",   16'd100,   16'd7, 16'd14,    16'd2,  1'b0, 17,    1'b0);
        run_op("5/9",     16'd5,     16'd9, 16'd0,     16'd5,  1'b0, 3,     1'b0);
        run_op("9/9",     16'd9,     16'd9, 16'd1,     16'd0,  1'b0, 4,     1'b0);
        run_op("42/0",    16'd42,    16'd0, 16'hFFFF,  16'd42, 1'b1, 3,     1'b0);
        run_op("20/4",    16'd20,    16'd4, 16'd5,     16'd0,  1'b0, 8,     1'b0);
        run_op("ffff/1",  16'hFFFF,  16'd1, 16'hFFFF,  16'd0,  1'b0, 65538, 1'b0);
        run_op("100/7 pulsed", 16'd100, 16'd7, 16'd14, 16'd2,  1'b0, 17,    1'b1);
        run_op("50/3",    16'd50,    16'd3, 16'd16,    16'd2,  1'b0, 19,    1'b0);

        // Start 200/3 and abort it with reset while in CALC.
        bus.start = 1'b1;
        bus.data_in = 16'd200;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.data_in = 16'd3;
        @(posedge clk); #1;
        bus.data_in = 16'hBEEF;
        repeat (5) @(posedge clk);
        #1;
        check("pre-abort busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort quotient",  32'(bus.quotient),  32'd0);
        check("abort remainder", 32'(bus.remainder), 32'd0);
        check("abort dbz",       32'(bus.dbz),       32'd0);
        check("abort busy",      32'(bus.busy),      32'd0);
        check("abort done",      32'(bus.done),      32'd0);
        #12;
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        check("post-abort idle", 32'(done_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_repsub.md
Name:
div_repsub

Overview:
- Sequential unsigned divider using repeated subtraction; the inverse operation of the team's repeated-addition multiplier.
- Controller and datapath are integrated in one block.
- Operands arrive over one shared data bus in two consecutive cycles, dividend first, then divisor.
- Produces quotient, remainder and a divide-by-zero flag, with a start/done handshake for the surrounding system controller.

Parameters:
- WIDTH, 16, bit width of the data bus, dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin an operation; sampled only in IDLE.
- data_in  input  WIDTH  operand bus; dividend in LDA cycle, divisor in LDB cycle.
- quotient  output  WIDTH  registered result quotient.
- remainder  output  WIDTH  registered result remainder.
- dbz  output  1  divisor was zero in the last completed operation.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset, asserted at any time including mid-operation:
  - state goes to IDLE; working registers clear.
  - quotient=0, remainder=0, dbz=0, done=0, busy=0.
  - Any in-flight operation is discarded.
- States: IDLE, LDA, LDB, CALC, DONE (3-bit encoding).
- IDLE: start=1 at a clock edge moves to LDA; otherwise stay.
- LDA: the edge leaving LDA captures data_in into the working remainder register (dividend); go to LDB.
- LDB: the edge leaving LDB captures data_in into the divisor register and clears the working quotient; go to CALC.
- CALC, evaluated each edge in this order:
  - divisor==0: working quotient set to all ones, working remainder kept (= dividend), zero flag set; go to DONE.
  - working remainder >= divisor (unsigned): remainder <= remainder - divisor, quotient <= quotient + 1; stay in CALC.
  - otherwise: go to DONE.
- Transition CALC->DONE loads the output registers quotient, remainder and dbz from the working values. Outputs hold until the next CALC->DONE transition or reset.
- DONE: done=1 for exactly this one cycle; unconditionally return to IDLE.
- Latency: with start sampled at edge E0, done is high from edge E(3+q) to edge E(4+q), where q is the final quotient (q=0 when the divisor is 0).
- Arithmetic:
  - Subtraction never underflows because it is guarded by the compare.
  - The quotient increment cannot overflow: the maximum is 2^WIDTH-1 with divisor=1.
- start while busy: ignored, with no effect on the operation in progress. Holding start high through DONE re-launches from IDLE on the next edge.
- busy is decoded from state and is high in LDA, LDB, CALC and DONE.
- data_in is don't-care outside the LDA and LDB cycles.

Test Plan:
- Dividend 100, divisor 7 -> quotient=14, remainder=2, dbz=0; done pulses one cycle, 17 edges after start sampled; busy high for 18 cycles.
- Dividend 5, divisor 9 -> quotient=0, remainder=5; done 3 edges after start. Dividend 9, divisor 9 -> quotient=1, remainder=0; done after 4 edges.
- Dividend 42, divisor 0 -> quotient=0xFFFF, remainder=42, dbz=1, done after 3 edges. A following 20/4 operation clears dbz and gives quotient=5, remainder=0.
- Dividend 0xFFFF, divisor 1 -> quotient=0xFFFF, remainder=0; done 65538 edges after start; no wrap of the quotient.
- Pulse start repeatedly during CALC of a 100/7 operation -> result unchanged (14/2) and exactly one done pulse.
- Run 50/3 to completion, then start 200/3 and assert rst_n=0 during CALC -> all outputs 0 and busy 0 immediately. After release, IDLE waits for start with no done pulse.
